// File: rtl/mod_pkg.sv
// Shared state encoding and default geometry for the modulation BRAM writer.
package mod_pkg;

  localparam int MOD_DEPTH_DEFAULT = 65536;
  localparam int MOD_ADDR_W        = 16;

  typedef enum logic [1:0] {
    IDLE,
    WR_LO,
    WR_HI,
    FINISH
  } mod_state_e;

endpackage

// File: rtl/modulation_bram_writer.sv
// Splits 16-bit stream words into byte samples, writes them to the modulation BRAM and publishes CYCLE.
// Define MOD_DOUBLE_BUFFER_EN for ping-pong banking (BANK output, BRAM_ADDR gains an MSB = !BANK).
module modulation_bram_writer
  import mod_pkg::*;
#(
  parameter int DEPTH  = MOD_DEPTH_DEFAULT,
  parameter int ADDR_W = MOD_ADDR_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CLEAR,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [15:0]       IN_DATA,
  input  logic              IN_KEEP_HI,
  input  logic              IN_LAST,
  output logic              BRAM_WE,
`ifdef MOD_DOUBLE_BUFFER_EN
  output logic [ADDR_W:0]   BRAM_ADDR,
  output logic              BANK,
`else
  output logic [ADDR_W-1:0] BRAM_ADDR,
`endif
  output logic [7:0]        BRAM_DIN,
  output logic [15:0]       CYCLE,
  output logic              CYCLE_VALID,
  output logic              OVERFLOW,
  output logic              BUSY
);

  // One extra pointer bit so a full load of DEPTH samples is representable.
  localparam int PTR_W = ADDR_W + 1;
  localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);
`ifdef MOD_DOUBLE_BUFFER_EN
  localparam int BA_W = ADDR_W + 1;
`else
  localparam int BA_W = ADDR_W;
`endif

  mod_state_e       state_q, state_d;
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [7:0]       hi_q, hi_d;
  logic             keep_hi_q, keep_hi_d;
  logic             last_q, last_d;
  logic             ready_q, ready_d;
  logic             we_q, we_d;
  logic [BA_W-1:0]  addr_q, addr_d;
  logic [7:0]       din_q, din_d;
  logic [15:0]      cycle_q, cycle_d;
  logic             cvalid_q, cvalid_d;
  logic             ovf_q, ovf_d;
  logic             busy_q;
  logic             bank_q, bank_d;

  logic             accept;
  logic             take;
  logic             finish;
  logic             wr_req;
  logic [7:0]       wr_byte;

  // CLEAR wins over a same-cycle handshake, so the word is refused rather than silently lost.
  assign IN_READY = ready_q && !CLEAR;
  assign accept   = IN_VALID && IN_READY;

  always_comb begin
    state_d   = state_q;
    wptr_d    = wptr_q;
    hi_d      = hi_q;
    keep_hi_d = keep_hi_q;
    last_d    = last_q;
    ready_d   = 1'b0;
    we_d      = 1'b0;
    addr_d    = addr_q;
    din_d     = din_q;
    cycle_d   = cycle_q;
    cvalid_d  = 1'b0;
    ovf_d     = ovf_q;
    bank_d    = bank_q;
    take      = 1'b0;
    finish    = 1'b0;
    wr_req    = 1'b0;
    wr_byte   = 8'h00;

    unique case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        take    = accept;
      end
      WR_LO: begin
        if (keep_hi_q) begin
          wr_req  = 1'b1;
          wr_byte = hi_q;
          state_d = WR_HI;
          ready_d = !last_q;
        end else if (last_q) begin
          finish = 1'b1;
        end else begin
          state_d = IDLE;
          ready_d = 1'b1;
        end
      end
      WR_HI: begin
        if (accept) begin
          take = 1'b1;
        end else if (last_q) begin
          finish = 1'b1;
        end else begin
          state_d = IDLE;
          ready_d = 1'b1;
        end
      end
      FINISH: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase

    // A zero pointer at accept time means this is the first word of a fresh load.
    if (take) begin
      hi_d      = IN_DATA[15:8];
      keep_hi_d = IN_KEEP_HI;
      last_d    = IN_LAST;
      wr_req    = 1'b1;
      wr_byte   = IN_DATA[7:0];
      state_d   = WR_LO;
      ready_d   = 1'b0;
      if (wptr_q == '0) ovf_d = 1'b0;
    end

    if (wr_req) begin
      if (wptr_q < DEPTH_P) begin
        we_d   = 1'b1;
`ifdef MOD_DOUBLE_BUFFER_EN
        addr_d = {!bank_q, wptr_q[ADDR_W-1:0]};
`else
        addr_d = wptr_q[ADDR_W-1:0];
`endif
        din_d  = wr_byte;
        wptr_d = wptr_q + PTR_W'(1);
      end else begin
        ovf_d = 1'b1;
      end
    end

    if (finish) begin
      state_d  = FINISH;
      cycle_d  = 16'(wptr_q - PTR_W'(1));
      cvalid_d = 1'b1;
      wptr_d   = '0;
      ready_d  = 1'b0;
      bank_d   = !bank_q;
    end

    if (CLEAR) begin
      state_d  = IDLE;
      wptr_d   = '0;
      ready_d  = 1'b1;
      we_d     = 1'b0;
      addr_d   = addr_q;
      din_d    = din_q;
      cycle_d  = cycle_q;
      cvalid_d = 1'b0;
      ovf_d    = 1'b0;
      bank_d   = bank_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      wptr_q    <= '0;
      hi_q      <= 8'h00;
      keep_hi_q <= 1'b0;
      last_q    <= 1'b0;
      ready_q   <= 1'b1;
      we_q      <= 1'b0;
      addr_q    <= '0;
      din_q     <= 8'h00;
      cycle_q   <= 16'h0000;
      cvalid_q  <= 1'b0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      bank_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wptr_q    <= wptr_d;
      hi_q      <= hi_d;
      keep_hi_q <= keep_hi_d;
      last_q    <= last_d;
      ready_q   <= ready_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      cycle_q   <= cycle_d;
      cvalid_q  <= cvalid_d;
      ovf_q     <= ovf_d;
      busy_q    <= (state_d != IDLE);
      bank_q    <= bank_d;
    end
  end

  assign BRAM_WE     = we_q;
  assign BRAM_ADDR   = addr_q;
  assign BRAM_DIN    = din_q;
  assign CYCLE       = cycle_q;
  assign CYCLE_VALID = cvalid_q;
  assign OVERFLOW    = ovf_q;
  assign BUSY        = busy_q;
`ifdef MOD_DOUBLE_BUFFER_EN
  assign BANK        = bank_q;
`endif

endmodule

// File: tb/tb_modulation_bram_writer.sv
// Directed bench for modulation_bram_writer with a small DEPTH so the overflow case stays short.
// Also covers the MOD_DOUBLE_BUFFER_EN build (BANK port and address MSB).
module tb_modulation_bram_writer;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 16;
`ifdef MOD_DOUBLE_BUFFER_EN
  localparam int BA_W = ADDR_W + 1;
`else
  localparam int BA_W = ADDR_W;
`endif

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            clear = 1'b0;
  logic            inValid = 1'b0;
  logic [15:0]     inData = 16'h0000;
  logic            inKeepHi = 1'b0;
  logic            inLast = 1'b0;
  logic            inReady;
  logic            bramWe;
  logic [BA_W-1:0] bramAddr;
  logic [7:0]      bramDin;
  logic [15:0]     cycle;
  logic            cycleValid;
  logic            overflow;
  logic            busy;
`ifdef MOD_DOUBLE_BUFFER_EN
  logic            bank;
`endif

  int testsRun = 0;
  int testsFailed = 0;
  int cyc = 0;
  int accCyc = 0;
  int cvCount = 0;
  int cvCyc = 0;
  logic [31:0] wrAddr[$];
  logic [7:0]  wrData[$];
  int          wrCyc[$];
  logic        wrReady[$];

  modulation_bram_writer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .CLK         (clock),
    .RST         (reset),
    .CLEAR       (clear),
    .IN_VALID    (inValid),
    .IN_READY    (inReady),
    .IN_DATA     (inData),
    .IN_KEEP_HI  (inKeepHi),
    .IN_LAST     (inLast),
    .BRAM_WE     (bramWe),
    .BRAM_ADDR   (bramAddr),
`ifdef MOD_DOUBLE_BUFFER_EN
    .BANK        (bank),
`endif
    .BRAM_DIN    (bramDin),
    .CYCLE       (cycle),
    .CYCLE_VALID (cycleValid),
    .OVERFLOW    (overflow),
    .BUSY        (busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Log every BRAM write and CYCLE_VALID pulse mid-cycle, away from the active edge.
  always @(negedge clock) begin
    if (bramWe) begin
      wrAddr.push_back(32'(bramAddr));
      wrData.push_back(bramDin);
      wrCyc.push_back(cyc);
      wrReady.push_back(inReady);
    end
    if (cycleValid) begin
      cvCount = cvCount + 1;
      cvCyc   = cyc;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun = testsRun + 1;
    if (observed !== expected) begin
      testsFailed = testsFailed + 1;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] addrAt(input int i);
    if (i < wrAddr.size()) return wrAddr[i] & ((32'd1 << ADDR_W) - 32'd1);
    return 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] msbAt(input int i);
    if (i < wrAddr.size()) return (wrAddr[i] >> ADDR_W) & 32'd1;
    return 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] dataAt(input int i);
    if (i < wrData.size()) return 32'(wrData[i]);
    return 32'hDEAD_BEEF;
  endfunction

  function automatic int cycAt(input int i);
    if (i < wrCyc.size()) return wrCyc[i];
    return -1000;
  endfunction

  function automatic logic [31:0] readyAt(input int i);
    if (i < wrReady.size()) return 32'(wrReady[i]);
    return 32'hDEAD_BEEF;
  endfunction

  task automatic clearLog();
    wrAddr.delete();
    wrData.delete();
    wrCyc.delete();
    wrReady.delete();
    cvCount = 0;
  endtask

  // Presents one word and holds it until the handshake; IN_VALID stays high for back-to-back use.
  task automatic applyStimulus(input logic [15:0] data, input logic keepHi, input logic last);
    logic accepted;
    accepted = 1'b0;
    inValid  = 1'b1;
    inData   = data;
    inKeepHi = keepHi;
    inLast   = last;
    for (int i = 0; i < 50 && !accepted; i++) begin
      @(negedge clock);
      accepted = inReady;
      accCyc   = cyc;
      @(posedge clock);
      #1;
    end
    if (!accepted) checkOutput("acceptTimeout", 32'd0, 32'd1);
  endtask

  task automatic endLoad();
    inValid = 1'b0;
    repeat (6) @(posedge clock);
    #1;
  endtask

  initial begin
    logic [15:0] t2Data[4];
    logic        t2Keep[4];
    int          t1Acc;

    t2Data = '{16'h2211, 16'h4433, 16'h6655, 16'h0077};
    t2Keep = '{1'b1, 1'b1, 1'b1, 1'b0};

    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    checkOutput("rstReady", 32'(inReady), 32'd1);
    checkOutput("rstWe", 32'(bramWe), 32'd0);
    checkOutput("rstAddr", 32'(bramAddr), 32'd0);
    checkOutput("rstDin", 32'(bramDin), 32'd0);
    checkOutput("rstCycle", 32'(cycle), 32'd0);
    checkOutput("rstCv", 32'(cycleValid), 32'd0);
    checkOutput("rstOvf", 32'(overflow), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    @(posedge clock);
    #1;

    // Single word, both bytes, last.
    clearLog();
    applyStimulus(16'hBBAA, 1'b1, 1'b1);
    t1Acc = accCyc;
    endLoad();
    checkOutput("t1Writes", 32'(wrAddr.size()), 32'd2);
    checkOutput("t1Addr0", addrAt(0), 32'd0);
    checkOutput("t1Din0", dataAt(0), 32'hAA);
    checkOutput("t1Addr1", addrAt(1), 32'd1);
    checkOutput("t1Din1", dataAt(1), 32'hBB);
    checkOutput("t1LoLatency", 32'(cycAt(0) - t1Acc), 32'd1);
    checkOutput("t1HiLatency", 32'(cycAt(1) - t1Acc), 32'd2);
    checkOutput("t1CvCount", 32'(cvCount), 32'd1);
    checkOutput("t1CvLatency", 32'(cvCyc - t1Acc), 32'd3);
    checkOutput("t1Cycle", 32'(cycle), 32'd1);
`ifdef MOD_DOUBLE_BUFFER_EN
    checkOutput("t1Msb0", msbAt(0), 32'd1);
    checkOutput("t1Msb1", msbAt(1), 32'd1);
    checkOutput("t1Bank", 32'(bank), 32'd1);
`endif

    // Four back-to-back words, last one low byte only.
    clearLog();
    for (int i = 0; i < 4; i++) applyStimulus(t2Data[i], t2Keep[i], i == 3);
    endLoad();
    checkOutput("t2Writes", 32'(wrAddr.size()), 32'd7);
    for (int i = 0; i < 7; i++) begin
      checkOutput($sformatf("t2Addr%0d", i), addrAt(i), 32'(i));
      checkOutput($sformatf("t2Din%0d", i), dataAt(i), 32'h11 * 32'(i + 1));
      checkOutput($sformatf("t2Gap%0d", i), 32'(cycAt(i) - cycAt(0)), 32'(i));
      checkOutput($sformatf("t2Ready%0d", i), readyAt(i), 32'(i % 2));
    end
    checkOutput("t2CvCount", 32'(cvCount), 32'd1);
    checkOutput("t2Cycle", 32'(cycle), 32'd6);
`ifdef MOD_DOUBLE_BUFFER_EN
    checkOutput("t2Msb0", msbAt(0), 32'd0);
    checkOutput("t2Bank", 32'(bank), 32'd0);
`endif

    // Abort with CLEAR after three words, then a refused word, then a fresh one-sample load.
    clearLog();
    applyStimulus(16'h0201, 1'b1, 1'b0);
    applyStimulus(16'h0403, 1'b1, 1'b0);
    applyStimulus(16'h0605, 1'b1, 1'b1);
    inValid = 1'b0;
    clear   = 1'b1;
    @(posedge clock);
    #1;
    clear = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("clrWrites", 32'(wrAddr.size()), 32'd5);
    checkOutput("clrNoCv", 32'(cvCount), 32'd0);
    checkOutput("clrBusy", 32'(busy), 32'd0);
    checkOutput("clrCycleKept", 32'(cycle), 32'd6);
    clear    = 1'b1;
    inValid  = 1'b1;
    inData   = 16'h00EE;
    inKeepHi = 1'b0;
    inLast   = 1'b1;
    @(negedge clock);
    checkOutput("clrReadyLow", 32'(inReady), 32'd0);
    @(posedge clock);
    #1;
    clear   = 1'b0;
    inValid = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("clrDropped", 32'(wrAddr.size()), 32'd5);
    applyStimulus(16'h0011, 1'b0, 1'b1);
    endLoad();
    checkOutput("clrNewWrites", 32'(wrAddr.size()), 32'd6);
    checkOutput("clrNewAddr", addrAt(5), 32'd0);
    checkOutput("clrNewDin", dataAt(5), 32'h11);
    checkOutput("clrNewCv", 32'(cvCount), 32'd1);
    checkOutput("clrNewCycle", 32'(cycle), 32'd0);

    // Reset while the high byte of an unfinished load is being written.
    applyStimulus(16'hBBAA, 1'b1, 1'b1);
    endLoad();
    checkOutput("rstPreCycle", 32'(cycle), 32'd1);
    clearLog();
    applyStimulus(16'h5544, 1'b1, 1'b0);
    @(posedge clock);
    #1;
    inValid = 1'b0;
    reset   = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    checkOutput("midRstReady", 32'(inReady), 32'd1);
    checkOutput("midRstWe", 32'(bramWe), 32'd0);
    checkOutput("midRstAddr", 32'(bramAddr), 32'd0);
    checkOutput("midRstDin", 32'(bramDin), 32'd0);
    checkOutput("midRstCycle", 32'(cycle), 32'd0);
    checkOutput("midRstBusy", 32'(busy), 32'd0);
    checkOutput("midRstCv", 32'(cycleValid), 32'd0);
    @(posedge clock);
    #1;
    clearLog();
    applyStimulus(16'h0099, 1'b0, 1'b1);
    endLoad();
    checkOutput("postRstAddr", addrAt(0), 32'd0);
    checkOutput("postRstDin", dataAt(0), 32'h99);
    checkOutput("postRstCycle", 32'(cycle), 32'd0);

    // DEPTH + 4 samples: writes stop at DEPTH - 1, OVERFLOW sticks until the next load starts.
    clearLog();
    for (int i = 0; i < (DEPTH + 4) / 2; i++)
      applyStimulus({8'(2 * i + 1), 8'(2 * i)}, 1'b1, i == (DEPTH + 4) / 2 - 1);
    endLoad();
    checkOutput("ovfWrites", 32'(wrAddr.size()), 32'(DEPTH));
    checkOutput("ovfLastAddr", addrAt(DEPTH - 1), 32'(DEPTH - 1));
    checkOutput("ovfLastDin", dataAt(DEPTH - 1), 32'(DEPTH - 1));
    checkOutput("ovfFlag", 32'(overflow), 32'd1);
    checkOutput("ovfCycle", 32'(cycle), 32'(DEPTH - 1));
    checkOutput("ovfCv", 32'(cvCount), 32'd1);
    clearLog();
    applyStimulus(16'h00CC, 1'b0, 1'b1);
    inValid = 1'b0;
    @(negedge clock);
    checkOutput("ovfCleared", 32'(overflow), 32'd0);
    endLoad();
    checkOutput("ovfNextAddr", addrAt(0), 32'd0);
    checkOutput("ovfNextDin", dataAt(0), 32'hCC);
    checkOutput("ovfNextCycle", 32'(cycle), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
